// File: rtl/fft_frame_ctrl.sv
// ----------------------------------------------------------------------------
// fft_frame_ctrl
//
// Frames a stream of real audio samples for an external in-place FFT core.
// Collects N = 2^LOG_DEPTH samples into the core, starts the transform, waits
// for completion and then reads the N bins back one at a time. Each bin is
// presented as a valid/ready output beat.
//
// Build option:
//   FFT_FRAME_CTRL_MAG_EN - when defined, each bin is reduced to the magnitude
//   estimate |re|+|im|, saturated to 2^(NB-1)-1, on out_real, with out_imag = 0.
//   When it is undefined, the raw core data is passed through.
//
// Ports:
//   clk, reset          clock and synchronous active-low reset
//   in_sample/valid/ready   sample input; in_ready is high only while filling
//   out_real/imag/bin   registered output bin and its index
//   out_valid/last/ready    output handshake; out_last marks bin N-1
//   overrun             sticky: a sample was offered while in_ready was low
//   frame_count         completed frames, wraps at 2^16
//   core_*              FFT core control, write port and read port
//
// LOG_DEPTH is legal from 3 to 12.
// ----------------------------------------------------------------------------
module fft_frame_ctrl #(
    parameter int unsigned NB        = 18,
    parameter int unsigned LOG_DEPTH = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NB-1:0]          in_sample,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [NB-1:0]          out_real,
    output logic [NB-1:0]          out_imag,
    output logic [LOG_DEPTH-1:0]   out_bin,
    output logic                   out_valid,
    output logic                   out_last,
    input  logic                   out_ready,
    output logic                   overrun,
    output logic [15:0]            frame_count,
    output logic                   core_start,
    input  logic                   core_done,
    output logic [LOG_DEPTH-1:0]   core_addr,
    output logic                   core_write_enable,
    output logic [2*NB-1:0]        core_write_data,
    output logic                   core_read_enable,
    input  logic                   core_read_valid,
    input  logic [2*NB-1:0]        core_read_data
);

    localparam logic [LOG_DEPTH-1:0] LastIdx = {LOG_DEPTH{1'b1}};

    typedef enum logic [2:0] {
        StFill,
        StStart,
        StWait,
        StRdReq,
        StRdWait,
        StHold
    } state_e;

    state_e               state;
    logic [LOG_DEPTH-1:0] wr_cnt;
    logic [LOG_DEPTH-1:0] rd_cnt;
    logic                 accept;
    logic [NB-1:0]        bin_real;
    logic [NB-1:0]        bin_imag;

    // Gated by reset so the source sees in_ready low while reset is held.
    assign in_ready          = reset && (state == StFill);
    assign accept            = in_ready && in_valid;
    assign core_write_enable = accept;
    assign core_write_data   = {{NB{1'b0}}, in_sample};
    assign core_start        = (state == StStart);
    assign core_read_enable  = (state == StRdReq);
    assign out_last          = out_valid && (out_bin == LastIdx);

    // Address is parked at 0 unless a write or read request is in flight.
    always_comb begin
        core_addr = '0;
        if (accept) begin
            core_addr = wr_cnt;
        end else if (state == StRdReq) begin
            core_addr = rd_cnt;
        end
    end

`ifdef FFT_FRAME_CTRL_MAG_EN
    localparam logic [NB-1:0] MagMax = {1'b0, {(NB-1){1'b1}}};

    logic signed [NB-1:0] rd_re;
    logic signed [NB-1:0] rd_im;
    logic [NB-1:0]        abs_re;
    logic [NB-1:0]        abs_im;
    logic [NB:0]          mag_sum;

    assign rd_re = core_read_data[NB-1:0];
    assign rd_im = core_read_data[2*NB-1:NB];
    // Negating the most negative value wraps to 2^(NB-1), which is the correct
    // magnitude when read as unsigned.
    assign abs_re  = rd_re[NB-1] ? $unsigned(-rd_re) : $unsigned(rd_re);
    assign abs_im  = rd_im[NB-1] ? $unsigned(-rd_im) : $unsigned(rd_im);
    assign mag_sum = {1'b0, abs_re} + {1'b0, abs_im};

    assign bin_real = (mag_sum > {1'b0, MagMax}) ? MagMax : mag_sum[NB-1:0];
    assign bin_imag = '0;
`else
    assign bin_real = core_read_data[NB-1:0];
    assign bin_imag = core_read_data[2*NB-1:NB];
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= StFill;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            out_valid   <= 1'b0;
            out_real    <= '0;
            out_imag    <= '0;
            out_bin     <= '0;
            overrun     <= 1'b0;
            frame_count <= '0;
        end else begin
            // Offered sample is dropped; only the flag records it.
            if (in_valid && !in_ready) begin
                overrun <= 1'b1;
            end

            unique case (state)
                StFill: begin
                    if (in_valid) begin
                        if (wr_cnt == LastIdx) begin
                            wr_cnt <= '0;
                            state  <= StStart;
                        end else begin
                            wr_cnt <= wr_cnt + 1'b1;
                        end
                    end
                end
                StStart: begin
                    state <= StWait;
                end
                StWait: begin
                    if (core_done) begin
                        rd_cnt <= '0;
                        state  <= StRdReq;
                    end
                end
                StRdReq: begin
                    state <= StRdWait;
                end
                StRdWait: begin
                    if (core_read_valid) begin
                        out_real  <= bin_real;
                        out_imag  <= bin_imag;
                        out_bin   <= rd_cnt;
                        out_valid <= 1'b1;
                        state     <= StHold;
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (rd_cnt == LastIdx) begin
                            frame_count <= frame_count + 16'd1;
                            state       <= StFill;
                        end else begin
                            rd_cnt <= rd_cnt + 1'b1;
                            state  <= StRdReq;
                        end
                    end
                end
                default: begin
                    state <= StFill;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fft_frame_ctrl
//
// Directed bench for fft_frame_ctrl with NB=18, LOG_DEPTH=3. A behavioural
// core model answers reads one cycle after core_read_enable with re=addr,
// im=-addr, or with re=-100000, im=100000 on a selected address.
// ----------------------------------------------------------------------------
module tb_fft_frame_ctrl;

    localparam int NB = 18;
    localparam int LD = 3;
    localparam int N  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [NB-1:0]     in_sample;
    logic              in_valid;
    logic              in_ready;
    logic [NB-1:0]     out_real;
    logic [NB-1:0]     out_imag;
    logic [LD-1:0]     out_bin;
    logic              out_valid;
    logic              out_last;
    logic              out_ready;
    logic              overrun;
    logic [15:0]       frame_count;
    logic              core_start;
    logic              core_done;
    logic [LD-1:0]     core_addr;
    logic              core_write_enable;
    logic [2*NB-1:0]   core_write_data;
    logic              core_read_enable;
    logic              core_read_valid = 1'b0;
    logic [2*NB-1:0]   core_read_data  = '0;

    int n_checks = 0;
    int n_fail   = 0;

    logic hold_rd     = 1'b0;
    int   special_bin = -1;
    int   wr_seen     = 0;

    always #5 clk = ~clk;

    fft_frame_ctrl #(
        .NB       (NB),
        .LOG_DEPTH(LD)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .in_sample        (in_sample),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .out_real         (out_real),
        .out_imag         (out_imag),
        .out_bin          (out_bin),
        .out_valid        (out_valid),
        .out_last         (out_last),
        .out_ready        (out_ready),
        .overrun          (overrun),
        .frame_count      (frame_count),
        .core_start       (core_start),
        .core_done        (core_done),
        .core_addr        (core_addr),
        .core_write_enable(core_write_enable),
        .core_write_data  (core_write_data),
        .core_read_enable (core_read_enable),
        .core_read_valid  (core_read_valid),
        .core_read_data   (core_read_data)
    );

    // Core model: 1-cycle read latency, counts writes.
    always @(posedge clk) begin
        core_read_valid <= core_read_enable && !hold_rd;
        if (int'(core_addr) == special_bin) begin
            core_read_data <= {NB'(100000), NB'(-100000)};
        end else begin
            core_read_data <= {NB'(-int'(core_addr)), NB'(int'(core_addr))};
        end
        if (core_write_enable) begin
            wr_seen <= wr_seen + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no end of test, required end of test");
        $fatal(1, "timeout");
    end

    // NB-bit two's-complement pattern of v, zero-extended.
    function automatic logic [63:0] fld(input int v);
        logic [NB-1:0] t;
        t = v[NB-1:0];
        return 64'(t);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Writes N samples base..base+N-1; returns in the START cycle.
    task automatic fill_frame(input int base);
        for (int i = 0; i < N; i++) begin
            in_valid  = 1'b1;
            in_sample = NB'(base + i);
            #1;
            check("fill_in_ready", in_ready, 1);
            check("fill_we", core_write_enable, 1);
            check("fill_addr", core_addr, i);
            check("fill_data", core_write_data, 64'(base + i));
            tick();
        end
        in_valid = 1'b0;
        #1;
        check("start_pulse", core_start, 1);
        check("start_in_ready", in_ready, 0);
        check("start_we", core_write_enable, 0);
    endtask

    // Pulses core_done from WAIT and drains the N bins.
    task automatic read_frame(input int stall_bin, input int spec_bin, input int fc_exp);
        int n;
        logic [63:0] er;
        logic [63:0] ei;
        special_bin = spec_bin;
        core_done   = 1'b1;
        tick();
        core_done = 1'b0;
        #1;
        check("rdreq_en", core_read_enable, 1);
        check("rdreq_addr", core_addr, 0);
        for (int k = 0; k < N; k++) begin
            out_ready = (k != stall_bin);
            n = 0;
            while (!out_valid && n < 20) begin
                tick();
                n++;
            end
            check("out_valid", out_valid, 1);
            if (k == 0) check("done_latency", n + 1, 3);
`ifdef FFT_FRAME_CTRL_MAG_EN
            er = (k == spec_bin) ? 64'd131071 : 64'(2 * k);
            ei = 0;
`else
            er = (k == spec_bin) ? fld(-100000) : fld(k);
            ei = (k == spec_bin) ? fld(100000) : fld(-k);
`endif
            check("out_real", out_real, er);
            check("out_imag", out_imag, ei);
            check("out_bin", out_bin, k);
            check("out_last", out_last, (k == N - 1) ? 1 : 0);
            if (k == stall_bin) begin
                for (int c = 0; c < 5; c++) begin
                    tick();
                    check("stall_valid", out_valid, 1);
                    check("stall_real", out_real, er);
                    check("stall_imag", out_imag, ei);
                    check("stall_bin", out_bin, k);
                    check("stall_no_rd", core_read_enable, 0);
                end
                out_ready = 1'b1;
            end
            if (k == N - 1) check("fc_before_last", frame_count, fc_exp);
            tick();
        end
        special_bin = -1;
        #1;
        check("frame_end_valid", out_valid, 0);
        check("frame_count", frame_count, fc_exp + 1);
        check("frame_end_ready", in_ready, 1);
    endtask

    initial begin
        int cnt0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_sample = '0;
        out_ready = 1'b1;
        core_done = 1'b0;
        repeat (3) tick();

        // Reset state; a sample offered during reset is neither written nor flagged.
        in_valid = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_we", core_write_enable, 0);
        tick();
        in_valid = 1'b0;
        #1;
        check("rst_overrun", overrun, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_real", out_real, 0);
        check("rst_out_imag", out_imag, 0);
        check("rst_out_bin", out_bin, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_core_start", core_start, 0);
        check("rst_core_addr", core_addr, 0);
        check("rst_core_re", core_read_enable, 0);

        reset = 1'b1;
        #1;
        check("rel_in_ready", in_ready, 1);

        // core_done outside WAIT is ignored.
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        #1;
        check("done_in_fill", in_ready, 1);
        check("done_in_fill_start", core_start, 0);

        // Frame 1: samples 1..8, stall on bin 3.
        fill_frame(1);
        tick();
        check("wait_start_low", core_start, 0);
        check("wait_in_ready", in_ready, 0);
        tick();
        check("wait_start_low2", core_start, 0);
        read_frame(3, -1, 0);
        check("f1_overrun", overrun, 0);

        // Frame 2: offer a sample during WAIT.
        fill_frame(11);
        tick();
        cnt0     = wr_seen;
        in_valid = 1'b1;
        #1;
        check("wait_offer_we", core_write_enable, 0);
        tick();
        in_valid = 1'b0;
        #1;
        check("overrun_set", overrun, 1);
        check("overrun_no_write", wr_seen, cnt0);
        read_frame(-1, 5, 1);
        check("overrun_sticky", overrun, 1);

        // Frame 3: reset pulse while stuck in RD_WAIT.
        fill_frame(21);
        tick();
        hold_rd   = 1'b1;
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        tick();
        tick();
        check("rdwait_valid", out_valid, 0);
        reset = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 0);
        tick();
        reset   = 1'b1;
        hold_rd = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_frame_count", frame_count, 0);
        check("midrst_overrun", overrun, 0);
        check("midrst_in_ready", in_ready, 1);
        in_valid  = 1'b1;
        in_sample = NB'(77);
        #1;
        check("midrst_we", core_write_enable, 1);
        check("midrst_addr", core_addr, 0);
        check("midrst_data", core_write_data, 77);
        tick();
        in_valid = 1'b0;
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
